// File: rtl/uart_serial_fifo_if.sv
// CSR bus between the CPU side and the serial UART.
//   csr_a  : address, [13:10] bank select, [3:0] register
//   csr_we : write strobe
//   csr_di : write data
//   csr_do : registered read data, valid one cycle after csr_a
interface uart_serial_fifo_if;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;

    modport master (
        output csr_a,
        output csr_we,
        output csr_di,
        input  csr_do
    );

    modport slave (
        input  csr_a,
        input  csr_we,
        input  csr_di,
        output csr_do
    );
endinterface

// File: rtl/uart_serial_fifo.sv
// CSR-mapped 8N1 UART with TX/RX FIFOs, programmable baud divisor, sticky
// error flags and a maskable level interrupt.
//   sys_clk : system clock, rising edge
//   sys_rst : asynchronous active-high reset
//   csr     : CSR bus (slave side), see uart_serial_fifo_if
//   uart_rx : serial input, asynchronous, idle high
//   uart_tx : serial output, idle high
//   irq     : registered level interrupt
//
// Register map (csr_a[3:0]):
//   0x0 RXDATA  rd {23'd0, rx_nonempty, head}  wr pops one entry
//   0x1 TXDATA  wr pushes csr_di[7:0]          rd 0
//   0x2 STATUS  {tx_busy, tx_overflow, framing_err, rx_overrun,
//                tx_full, tx_empty, rx_full, rx_nonempty}, W1C on [6:4]
//   0x3 DIVISOR bit period = DIVISOR+1 cycles, minimum 3
//   0x4 CTRL    {tx_irq_en, rx_irq_en}
//
// FSM states (TX and RX share the same names):
//   state | meaning
//   IDLE  | no frame in progress
//   START | start bit (TX: driving 0, RX: waiting for mid start bit)
//   DATA  | 8 data bits, LSB first
//   STOP  | stop bit (TX: driving 1, RX: waiting for mid stop bit)

// Byte FIFO: circular buffer with separate occupancy count.
//   push/wdata : enqueue, honoured when not full or when popping
//   pop        : dequeue, ignored when empty
//   head       : oldest entry
//   empty/full : occupancy flags
module uart_serial_fifo_buf #(
    parameter int AW = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);
    localparam int          DEPTH    = 1 << AW;
    localparam int          CW       = AW + 1;
    localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge sys_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

module uart_serial_fifo #(
    parameter logic [3:0]  csr_addr        = 4'h0,
    parameter int          FIFO_DEPTH_LOG2 = 4,
    parameter logic [15:0] CLK_DIV_DEFAULT = 16'd433
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    uart_serial_fifo_if.slave csr,
    input  logic              uart_rx,
    output logic              uart_tx,
    output logic              irq
);
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // ---------------- register file / decode ----------------
    logic        bank_sel;
    logic [3:0]  reg_sel;
    logic        wr_rxdata;
    logic        wr_txdata;
    logic        wr_status;
    logic        wr_divisor;
    logic        wr_ctrl;
    logic [15:0] divisor;
    logic [1:0]  ctrl;
    logic        rx_overrun;
    logic        framing_err;
    logic        tx_overflow;
    logic [31:0] rd_data;
    logic        unused_bits;

    assign bank_sel   = (csr.csr_a[13:10] == csr_addr);
    assign reg_sel    = csr.csr_a[3:0];
    assign wr_rxdata  = bank_sel & csr.csr_we & (reg_sel == 4'h0);
    assign wr_txdata  = bank_sel & csr.csr_we & (reg_sel == 4'h1);
    assign wr_status  = bank_sel & csr.csr_we & (reg_sel == 4'h2);
    assign wr_divisor = bank_sel & csr.csr_we & (reg_sel == 4'h3);
    assign wr_ctrl    = bank_sel & csr.csr_we & (reg_sel == 4'h4);
    // Address and data bits this block does not decode.
    assign unused_bits = ^{csr.csr_a[9:4], csr.csr_di[31:16]};

    // ---------------- FIFOs ----------------
    tx_state_t   tx_state;
    rx_state_t   rx_state;
    logic        tx_push;
    logic        tx_pop;
    logic        tx_empty;
    logic        tx_full;
    logic [7:0]  tx_head;
    logic        tx_busy;
    logic        rx_push;
    logic        rx_pop;
    logic        rx_empty;
    logic        rx_full;
    logic [7:0]  rx_head;
    logic [7:0]  rx_shift;

    assign tx_push = wr_txdata;
    assign rx_pop  = wr_rxdata & ~rx_empty;

    uart_serial_fifo_buf #(.AW(FIFO_DEPTH_LOG2)) u_tx_fifo (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .push    (tx_push),
        .pop     (tx_pop),
        .wdata   (csr.csr_di[7:0]),
        .head    (tx_head),
        .empty   (tx_empty),
        .full    (tx_full)
    );

    uart_serial_fifo_buf #(.AW(FIFO_DEPTH_LOG2)) u_rx_fifo (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .push    (rx_push),
        .pop     (rx_pop),
        .wdata   (rx_shift),
        .head    (rx_head),
        .empty   (rx_empty),
        .full    (rx_full)
    );

    // ---------------- TX FSM ----------------
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_bit_end;

    assign tx_bit_end = (tx_cnt == 16'd0);
    assign tx_busy    = (tx_state != TX_IDLE);
    // Popping at the end of the stop bit chains frames with no idle gap.
    assign tx_pop     = ~tx_empty &
                        ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & tx_bit_end));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_state <= TX_START;
                        tx_shift <= tx_head;
                        tx_cnt   <= divisor;
                        uart_tx  <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_state <= TX_DATA;
                        tx_cnt   <= divisor;
                        tx_bit   <= 3'd0;
                        uart_tx  <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt <= divisor;
                        if (tx_bit == 3'd7) begin
                            tx_state <= TX_STOP;
                            uart_tx  <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            uart_tx  <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end) begin
                        if (tx_pop) begin
                            tx_state <= TX_START;
                            tx_shift <= tx_head;
                            tx_cnt   <= divisor;
                            uart_tx  <= 1'b0;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    uart_tx  <= 1'b1;
                end
            endcase
        end
    end

    // ---------------- RX synchroniser and FSM ----------------
    logic [1:0]  rx_sync;
    logic        rx_line;
    logic        rx_prev;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [16:0] div_plus1;
    logic [15:0] rx_half_m1;
    logic        rx_stop_sample;
    logic        frame_set;
    logic        overrun_set;

    assign rx_line        = rx_sync[1];
    assign div_plus1      = {1'b0, divisor} + 17'd1;
    assign rx_half_m1     = 16'(div_plus1 >> 1) - 16'd1;
    assign rx_stop_sample = (rx_state == RX_STOP) & (rx_cnt == 16'd0);
    assign rx_push        = rx_stop_sample & rx_line;
    assign frame_set      = rx_stop_sample & ~rx_line;
    assign overrun_set    = rx_push & rx_full & ~rx_pop;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], uart_rx};
            rx_prev <= rx_line;
        end
    end

    // Only a genuine 1->0 edge leaves IDLE, so after a framing error the
    // line must go high again before the next frame is accepted.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev & ~rx_line) begin
                        rx_state <= RX_START;
                        rx_cnt   <= rx_half_m1;
                    end
                end
                RX_START: begin
                    if (rx_cnt == 16'd0) begin
                        if (~rx_line) begin
                            rx_state <= RX_DATA;
                            rx_cnt   <= divisor;
                            rx_bit   <= 3'd0;
                        end else begin
                            rx_state <= RX_IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == 16'd0) begin
                        rx_shift <= {rx_line, rx_shift[7:1]};
                        rx_cnt   <= divisor;
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == 16'd0) begin
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------- registers, irq, read data ----------------
    always_comb begin
        rd_data = '0;
        if (bank_sel) begin
            case (reg_sel)
                4'h0: rd_data = {23'd0, ~rx_empty, rx_empty ? 8'h00 : rx_head};
                4'h2: rd_data = {24'd0, tx_busy, tx_overflow, framing_err, rx_overrun,
                                 tx_full, tx_empty, rx_full, ~rx_empty};
                4'h3: rd_data = {16'd0, divisor};
                4'h4: rd_data = {30'd0, ctrl};
                default: rd_data = '0;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as a W1C clear wins.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            divisor     <= CLK_DIV_DEFAULT;
            ctrl        <= '0;
            rx_overrun  <= 1'b0;
            framing_err <= 1'b0;
            tx_overflow <= 1'b0;
            irq         <= 1'b0;
            csr.csr_do  <= '0;
        end else begin
            if (wr_divisor) begin
                divisor <= (csr.csr_di[15:0] < 16'd3) ? 16'd3 : csr.csr_di[15:0];
            end
            if (wr_ctrl) begin
                ctrl <= csr.csr_di[1:0];
            end
            rx_overrun  <= overrun_set | (rx_overrun & ~(wr_status & csr.csr_di[4]));
            framing_err <= frame_set | (framing_err & ~(wr_status & csr.csr_di[5]));
            tx_overflow <= (wr_txdata & tx_full & ~tx_pop) |
                           (tx_overflow & ~(wr_status & csr.csr_di[6]));
            irq         <= (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_empty & ~tx_busy);
            csr.csr_do  <= rd_data;
        end
    end
endmodule

// File: tb/tb_uart_serial_fifo.sv
// Self-checking bench for uart_serial_fifo: directed CSR/serial stimulus,
// a bench-side model of the RX FIFO contents and sticky flags, and a
// serial line decoder that checks every transmitted frame against the
// queue of bytes expected on uart_tx.
module tb_uart_serial_fifo;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    logic uart_rx = 1'b1;
    logic uart_tx;
    logic irq;

    uart_serial_fifo_if bus ();

    uart_serial_fifo dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .csr     (bus),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx),
        .irq     (irq)
    );

    always #5 sys_clk = ~sys_clk;

    int         checks = 0;
    int         errors = 0;
    int         m_div  = 433;
    logic [7:0] rx_q[$];
    logic [7:0] exp_tx[$];
    bit         m_ovr  = 1'b0;
    bit         m_frm  = 1'b0;
    bit         m_txovf = 1'b0;
    bit         mon_en = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected STATUS while the transmitter is idle with an empty FIFO.
    function automatic logic [31:0] exp_status();
        return {24'd0, 1'b0, m_txovf, m_frm, m_ovr, 1'b0, 1'b1,
                rx_q.size() == 16, rx_q.size() != 0};
    endfunction

    function automatic logic [31:0] exp_rxdata();
        if (rx_q.size() == 0) return 32'd0;
        return {23'd0, 1'b1, rx_q[0]};
    endfunction

    task automatic csr_rd_a(input logic [13:0] a, output logic [31:0] d);
        @(negedge sys_clk);
        bus.csr_a  = a;
        bus.csr_we = 1'b0;
        @(negedge sys_clk);
        d = bus.csr_do;
    endtask

    task automatic csr_rd(input logic [3:0] r, output logic [31:0] d);
        csr_rd_a({4'h0, 6'd0, r}, d);
    endtask

    task automatic csr_wr(input logic [3:0] r, input logic [31:0] v);
        @(negedge sys_clk);
        bus.csr_a  = {4'h0, 6'd0, r};
        bus.csr_di = v;
        bus.csr_we = 1'b1;
        @(negedge sys_clk);
        bus.csr_we = 1'b0;
    endtask

    task automatic set_div(input int v);
        csr_wr(4'h3, 32'(v));
        m_div = (v < 3) ? 3 : v;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            uart_rx = f[i];
            repeat (m_div) @(negedge sys_clk);
        end
        @(negedge sys_clk);
        uart_rx = 1'b1;
        repeat (m_div + 4) @(negedge sys_clk);
        if (stop) begin
            if (rx_q.size() < 16) rx_q.push_back(b);
            else m_ovr = 1'b1;
        end else begin
            m_frm = 1'b1;
        end
    endtask

    // Serial decoder: samples mid-bit, checks framing and the byte order.
    initial begin : tx_monitor
        logic       prev_tx;
        logic [7:0] got;
        logic [7:0] want;
        int         p;
        prev_tx = 1'b1;
        got     = '0;
        forever begin
            @(negedge sys_clk);
            if (mon_en && prev_tx && !uart_tx) begin
                p = m_div + 1;
                repeat (p / 2) @(negedge sys_clk);
                if (mon_en) chk("tx_start_bit", 32'(uart_tx), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (p) @(negedge sys_clk);
                    got[i] = uart_tx;
                end
                repeat (p) @(negedge sys_clk);
                if (mon_en) begin
                    chk("tx_stop_bit", 32'(uart_tx), 32'd1);
                    if (exp_tx.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected_byte: got %h expected none", got);
                    end else begin
                        want = exp_tx.pop_front();
                        chk("tx_byte", 32'(got), 32'(want));
                    end
                end
            end
            prev_tx = uart_tx;
        end
    end

    initial begin : watchdog
        #900000;
        errors++;
        $display("FAIL global_timeout: got running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] d;
        logic [9:0]  fa;
        bus.csr_a  = '0;
        bus.csr_we = 1'b0;
        bus.csr_di = '0;

        // reset values
        #1 sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        chk("rst_csr_do", bus.csr_do, 32'd0);
        chk("rst_uart_tx", 32'(uart_tx), 32'd1);
        chk("rst_irq", 32'(irq), 32'd0);
        sys_rst = 1'b0;
        csr_rd(4'h2, d); chk("rst_status", d, 32'h04); chk("rst_status_model", d, exp_status());
        csr_rd(4'h3, d); chk("rst_divisor", d, 32'd433);
        csr_rd(4'h4, d); chk("rst_ctrl", d, 32'd0);
        csr_rd(4'h0, d); chk("rst_rxdata", d, 32'd0);

        // decode: other bank, unmapped register, write-only TXDATA
        csr_rd_a({4'h1, 6'd0, 4'h2}, d); chk("other_bank", d, 32'd0);
        csr_rd(4'h7, d); chk("unmapped", d, 32'd0);
        csr_rd(4'h1, d); chk("txdata_read", d, 32'd0);

        // divisor clamp
        set_div(1);
        csr_rd(4'h3, d); chk("div_clamp", d, 32'd3);

        // TX waveform of 0xA5 at 4 cycles per bit
        set_div(3);
        exp_tx.push_back(8'hA5);
        csr_wr(4'h1, 32'hA5);
        chk("a5_line_after_write", 32'(uart_tx), 32'd1);
        fa = 10'b1_1010_0101_0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            chk("a5_wave", 32'(uart_tx), 32'(fa[i / 4]));
        end
        @(negedge sys_clk);
        chk("a5_idle_line", 32'(uart_tx), 32'd1);
        csr_rd(4'h2, d); chk("a5_status", d, 32'h04);

        // RX one byte, then pop
        set_div(7);
        send_frame(8'h3C, 1'b1);
        csr_rd(4'h2, d); chk("rx3c_status", d, exp_status()); chk("rx3c_status_lit", d, 32'h05);
        csr_rd(4'h0, d); chk("rx3c_data", d, exp_rxdata()); chk("rx3c_data_lit", d, 32'h13C);
        csr_wr(4'h0, 32'd0); void'(rx_q.pop_front());
        csr_rd(4'h0, d); chk("rx3c_popped", d, 32'd0);

        // interrupt
        csr_wr(4'h4, 32'd1);
        repeat (2) @(negedge sys_clk);
        chk("irq_rx_empty", 32'(irq), 32'd0);
        send_frame(8'h5A, 1'b1);
        chk("irq_rx_byte", 32'(irq), 32'd1);
        csr_wr(4'h0, 32'd0); void'(rx_q.pop_front());
        repeat (2) @(negedge sys_clk);
        chk("irq_rx_popped", 32'(irq), 32'd0);
        csr_wr(4'h4, 32'd2);
        repeat (2) @(negedge sys_clk);
        chk("irq_tx_idle", 32'(irq), 32'd1);
        csr_wr(4'h4, 32'd0);
        repeat (2) @(negedge sys_clk);
        chk("irq_masked", 32'(irq), 32'd0);

        // one-cycle glitch: false start
        @(negedge sys_clk); uart_rx = 1'b0;
        @(negedge sys_clk); uart_rx = 1'b1;
        repeat (3 * (m_div + 1)) @(negedge sys_clk);
        csr_rd(4'h2, d); chk("glitch_status", d, exp_status());

        // framing error
        send_frame(8'h55, 1'b0);
        csr_rd(4'h2, d); chk("frame_status", d, exp_status()); chk("frame_status_lit", d, 32'h24);
        csr_wr(4'h2, 32'h20); m_frm = 1'b0;
        csr_rd(4'h2, d); chk("frame_cleared", d, exp_status());

        // RX overrun: 17 frames into 16 entries
        for (int i = 0; i < 17; i++) send_frame(8'(8'h40 + i), 1'b1);
        csr_rd(4'h2, d); chk("rx_full_status", d, exp_status()); chk("rx_full_status_lit", d, 32'h17);
        csr_wr(4'h2, 32'h10); m_ovr = 1'b0;
        csr_rd(4'h2, d); chk("overrun_cleared", d, 32'h07);
        for (int i = 0; i < 16; i++) begin
            csr_rd(4'h0, d); chk("rx_drain", d, exp_rxdata());
            csr_wr(4'h0, 32'd0); void'(rx_q.pop_front());
        end
        csr_rd(4'h2, d); chk("rx_drained_status", d, 32'h04);

        // TX overflow: 18 writes, 17 accepted
        set_div(99);
        for (int i = 0; i < 18; i++) begin
            csr_wr(4'h1, 32'(8'h10 + i));
            if (i < 17) exp_tx.push_back(8'(8'h10 + i));
        end
        m_txovf = 1'b1;
        csr_rd(4'h2, d); chk("tx_overflow_status", d, 32'hC8);
        csr_wr(4'h2, 32'h40); m_txovf = 1'b0;
        csr_rd(4'h2, d); chk("tx_overflow_cleared", d, 32'h88);
        for (int n = 0; n < 12000; n++) begin
            csr_rd(4'h2, d);
            if (d[7] == 1'b0 && d[2] == 1'b1) break;
        end
        chk("tx_drain_status", d, exp_status());
        repeat (5) @(negedge sys_clk);
        chk("tx_all_sent", 32'(exp_tx.size()), 32'd0);

        // reset in the middle of a TX frame
        set_div(3);
        csr_wr(4'h4, 32'd1);
        send_frame(8'h77, 1'b1);
        chk("pre_rst_irq", 32'(irq), 32'd1);
        mon_en = 1'b0;
        csr_wr(4'h1, 32'h00);
        repeat (6) @(negedge sys_clk);
        chk("midtx_line_low", 32'(uart_tx), 32'd0);
        #2 sys_rst = 1'b1;
        #1;
        chk("async_rst_tx", 32'(uart_tx), 32'd1);
        chk("async_rst_irq", 32'(irq), 32'd0);
        chk("async_rst_csr_do", bus.csr_do, 32'd0);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        rx_q.delete();
        exp_tx.delete();
        m_ovr = 1'b0; m_frm = 1'b0; m_txovf = 1'b0; m_div = 433;
        csr_rd(4'h2, d); chk("post_rst_status", d, exp_status());
        csr_rd(4'h3, d); chk("post_rst_divisor", d, 32'd433);
        csr_rd(4'h4, d); chk("post_rst_ctrl", d, 32'd0);
        csr_rd(4'h0, d); chk("post_rst_rxdata", d, 32'd0);
        chk("post_rst_irq", 32'(irq), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
